// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: sequences EX/MEM data-memory accesses over req/ack,
// freezing the pipeline and bounding each access with a timeout.
// Optional stall-cycle counter port: define DMEM_STALL_CNT_EN.
module dmem_stall_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
`ifdef DMEM_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        access;
  logic        timeout_hit;

  assign access      = mem_read_i | mem_write_i;
  assign timeout_hit = (cnt == CNT_LAST);

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: DONE never samples access, so a retiring op cannot retrigger.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (access) state_nxt = BUSY;
      BUSY:    if (mem_ack_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Freeze the pipeline from the first access cycle until DONE.
  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      IDLE:    stall_o = access;
      BUSY:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // Request, latched access fields, read-data return and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
      cnt           <= '0;
    end else begin
      mem_req_o     <= (state_nxt == BUSY);
      rdata_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access) begin
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            mem_we_o    <= mem_write_i;
            cnt         <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              rdata_o       <= mem_rdata_i;
              rdata_valid_o <= 1'b1;
            end
          end else if (timeout_hit) begin
            err_o <= 1'b1;
            if (!mem_we_o) begin
              rdata_o       <= '0;
              rdata_valid_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_STALL_CNT_EN
  // Saturating count of frozen cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: directed stimulus, transaction-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_dmem_stall_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        req;
  logic        we;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic        ack = 1'b0;
  logic [31:0] mrdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
`ifdef DMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  dmem_stall_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mem_read_i(rd),
    .mem_write_i(wr),
    .addr_i(addr),
    .wdata_i(wdata),
    .mem_req_o(req),
    .mem_we_o(we),
    .mem_addr_o(maddr),
    .mem_wdata_o(mwdata),
    .mem_ack_i(ack),
    .mem_rdata_i(mrdata),
    .stall_o(stall),
    .rdata_o(rdata),
    .rdata_valid_o(rvalid),
`ifdef DMEM_STALL_CNT_EN
    .stall_cnt_o(stall_cnt),
`endif
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, described by whether
  // the memory is being asked, how long it has waited, and whether the
  // access is retiring this cycle.
  bit          m_asking;
  bit          m_retiring;
  int          m_waited;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  bit          m_rvalid;
  bit          m_err;
  longint      m_scnt;

  function automatic bit exp_stall();
    return m_asking || (!m_retiring && (rd || wr));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_asking = 0; m_retiring = 0; m_waited = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_rvalid = 0;
      m_err = 0; m_scnt = 0;
    end else begin
      if (exp_stall() && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      m_rvalid = 0;
      if (m_retiring) begin
        m_retiring = 0;
      end else if (m_asking) begin
        m_waited++;
        if (ack || m_waited == TIMEOUT) begin
          if (!ack) m_err = 1;
          m_asking = 0;
          m_retiring = 1;
          if (!m_we) begin
            m_rdata = ack ? mrdata : 32'h0;
            m_rvalid = 1;
          end
        end
      end else if (rd || wr) begin
        m_asking = 1;
        m_waited = 0;
        m_we = wr;
        m_addr = addr;
        m_wdata = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", {31'b0, req}, {31'b0, m_asking});
      chk("we", {31'b0, we}, {31'b0, m_we});
      chk("addr", maddr, m_addr);
      chk("wdata", mwdata, m_wdata);
      chk("stall", {31'b0, stall}, {31'b0, exp_stall()});
      chk("rdata", rdata, m_rdata);
      chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      chk("err", {31'b0, err}, {31'b0, m_err});
`ifdef DMEM_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(m_scnt));
`endif
    end
  end

  // Present one access; ack on busy cycle ack_at (0 = never). Returns
  // at posedge+1 of the idle cycle after retirement, access still driven.
  task automatic run_access(
    input bit rd_v, input bit wr_v,
    input logic [31:0] a, input logic [31:0] wd,
    input int ack_at, input logic [31:0] rdv,
    output int st_n, output int rq_n, output int rv_n);
    int last;
    last = (ack_at > 0) ? ack_at + 1 : TIMEOUT + 1;
    st_n = 0; rq_n = 0; rv_n = 0;
    rd = rd_v; wr = wr_v; addr = a; wdata = wd;
    for (int c = 0; c <= last; c++) begin
      ack = (ack_at > 0) && (c == ack_at);
      mrdata = ack ? rdv : 32'hA5A5_A5A5;
      @(negedge clk);
      st_n += int'(stall);
      rq_n += int'(req);
      rv_n += int'(rvalid);
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  task automatic go_idle(input int n);
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int st, rq, rv;

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_req", {31'b0, req}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    go_idle(1);

    // Read, acked on first busy cycle
    run_access(1, 0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, st, rq, rv);
    chk("s1_stall_cycles", st, 2);
    chk("s1_req_cycles", rq, 1);
    chk("s1_rvalid_pulses", rv, 1);
    chk("s1_rdata", rdata, 32'hDEAD_BEEF);
    chk("s1_addr", maddr, 32'h40);
    go_idle(1);

    // Write, acked after 5 busy cycles
    run_access(0, 1, 32'h80, 32'h1234_5678, 5, 32'h0, st, rq, rv);
    chk("s2_stall_cycles", st, 6);
    chk("s2_req_cycles", rq, 5);
    chk("s2_rvalid_pulses", rv, 0);
    chk("s2_rdata_held", rdata, 32'hDEAD_BEEF);
    chk("s2_wdata", mwdata, 32'h1234_5678);
    chk("s2_we", {31'b0, we}, 32'd1);
`ifdef DMEM_STALL_CNT_EN
    chk("stall_cnt_s1s2", stall_cnt, 32'd8);
`endif

    // Stray acks while idle are ignored
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1; mrdata = 32'hFFFF_0000;
      @(posedge clk); #1;
    end
    ack = 1'b0;
    chk("idle_ack_rdata", rdata, 32'hDEAD_BEEF);

    // Read that never gets acked
    run_access(1, 0, 32'h100, 32'h0, 0, 32'h0, st, rq, rv);
    chk("to_req_cycles", rq, TIMEOUT);
    chk("to_stall_cycles", st, TIMEOUT + 1);
    chk("to_rvalid_pulses", rv, 1);
    chk("to_rdata_zero", rdata, 32'h0);
    chk("to_err", {31'b0, err}, 32'd1);
    go_idle(2);

    // A later access still completes; error stays sticky
    run_access(0, 1, 32'h104, 32'hCAFE_F00D, 2, 32'h0, st, rq, rv);
    chk("post_to_stall", st, 3);
    chk("post_to_err", {31'b0, err}, 32'd1);

    // Back-to-back loads
    run_access(1, 0, 32'h10, 32'h0, 1, 32'h1111_1111, st, rq, rv);
    chk("b2b_first_rv", rv, 1);
    chk("b2b_first_rdata", rdata, 32'h1111_1111);
    run_access(1, 0, 32'h14, 32'h0, 1, 32'h2222_2222, st, rq, rv);
    chk("b2b_second_stall", st, 2);
    chk("b2b_second_rv", rv, 1);
    chk("b2b_second_rdata", rdata, 32'h2222_2222);
    go_idle(2);

    // Reset during busy cycle 3
    rd = 1'b1; addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_req", {31'b0, req}, 32'd1);
    rst = 1'b1; rd = 1'b0;
    #1;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    go_idle(1);
    run_access(1, 0, 32'h24, 32'h0, 3, 32'h0BAD_CAFE, st, rq, rv);
    chk("after_rst_stall", st, 4);
    chk("after_rst_rdata", rdata, 32'h0BAD_CAFE);
    go_idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
